// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: main-memory controller behind a direct-mapped write-back cache.
// It owns a 2**ADDR_W x DATA_W backing store and services each miss as one line transaction:
// an optional 16-word write-back of the dirty victim, then MEM_LAT wait cycles,
// then a 16-word refill burst returned one word per cycle.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            miss request handshake (ready only when idle)
//   req_dirty                      victim must be written back before the fill
//   req_victim_line/req_fill_line  line addresses {tag,index}
//   wb_ready/wb_idx/wb_data        write-back slot; cache drives wb_data from wb_idx
//   fill_valid/fill_idx/fill_data  refill word stream; fill_last marks word 15
//   done                           one-cycle completion pulse
//   busy                           inverse of req_ready
module line_fill_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_dirty,
  input  logic [ADDR_W-5:0]    req_victim_line,
  input  logic [ADDR_W-5:0]    req_fill_line,
  output logic                 wb_ready,
  output logic [3:0]           wb_idx,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 fill_valid,
  output logic [3:0]           fill_idx,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 fill_last,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LINE_W = ADDR_W - IDX_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [IDX_W-1:0] WAIT_END = IDX_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_WAIT,
    S_FILL,
    S_DONE
  } state_e;

  // Backing store; contents survive reset, power-up image is fixed
  logic [DATA_W-1:0] mem_q [DEPTH] = '{
    0:       DATA_W'(1500),
    1:       DATA_W'(1020),
    16:      DATA_W'(156),
    128:     DATA_W'(32),
    default: '0
  };

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   victim_q, victim_d;
  logic [LINE_W-1:0]   fline_q, fline_d;

  logic                req_ready_q;
  logic                wb_ready_q;
  logic [IDX_W-1:0]    wb_idx_q;
  logic                fill_valid_q;
  logic [IDX_W-1:0]    fill_idx_q;
  logic [DATA_W-1:0]   fill_data_q;
  logic                fill_last_q;
  logic                done_q;
  logic                busy_q;

  // Next-state: one counter serves as word index in WB/FILL and latency count in WAIT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    victim_d = victim_q;
    fline_d  = fline_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          victim_d = req_victim_line;
          fline_d  = req_fill_line;
          cnt_d    = '0;
          state_d  = req_dirty ? S_WB : S_WAIT;
        end
      end
      S_WB: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_FILL: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they
  // line up with the cycle the state is actually in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      victim_q     <= '0;
      fline_q      <= '0;
      req_ready_q  <= 1'b0;
      wb_ready_q   <= 1'b0;
      wb_idx_q     <= '0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
      fill_last_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      fline_q      <= fline_d;
      req_ready_q  <= (state_d == S_IDLE);
      wb_ready_q   <= (state_d == S_WB);
      wb_idx_q     <= (state_d == S_WB) ? cnt_d : '0;
      fill_valid_q <= (state_d == S_FILL);
      fill_idx_q   <= (state_d == S_FILL) ? cnt_d : '0;
      // Read issued one cycle ahead so the word lands with fill_valid
      fill_data_q  <= (state_d == S_FILL) ? mem_q[{fline_d, cnt_d}] : '0;
      fill_last_q  <= (state_d == S_FILL) && (cnt_d == LAST_IDX);
      done_q       <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  // Write-back port: the cache presents the word for wb_idx in the same cycle
  always_ff @(posedge clk) begin
    if (wb_ready_q) begin
      mem_q[{victim_q, wb_idx_q}] <= wb_data;
    end
  end

  assign req_ready  = req_ready_q;
  assign wb_ready   = wb_ready_q;
  assign wb_idx     = wb_idx_q;
  assign fill_valid = fill_valid_q;
  assign fill_idx   = fill_idx_q;
  assign fill_data  = fill_data_q;
  assign fill_last  = fill_last_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: directed bench for line_fill_ctrl.
// Cycle c=1 is the cycle right after the accept edge; outputs are sampled on the falling edge.
module tb_line_fill_ctrl;

  localparam int unsigned MEM_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_dirty;
  logic [11:0] req_victim_line;
  logic [11:0] req_fill_line;
  logic        wb_ready;
  logic [3:0]  wb_idx;
  logic [15:0] wb_data;
  logic        fill_valid;
  logic [3:0]  fill_idx;
  logic [15:0] fill_data;
  logic        fill_last;
  logic        done;
  logic        busy;

  logic [15:0] wb_base;
  logic [15:0] exp_fill [16];
  int unsigned n_vec;
  int unsigned n_miss;

  line_fill_ctrl #(
    .DATA_W (16),
    .ADDR_W (16),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dirty      (req_dirty),
    .req_victim_line(req_victim_line),
    .req_fill_line  (req_fill_line),
    .wb_ready       (wb_ready),
    .wb_idx         (wb_idx),
    .wb_data        (wb_data),
    .fill_valid     (fill_valid),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .fill_last      (fill_last),
    .done           (done),
    .busy           (busy)
  );

  // Cache model: victim word is a base value plus the requested offset
  assign wb_data = wb_base + 16'(wb_idx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ctl_now();
    return {wb_ready, wb_idx, fill_valid, fill_idx, fill_last, done, req_ready, busy};
  endfunction

  // Expected control outputs in cycle c of a transaction
  function automatic logic [13:0] ctl_exp(input int c, input logic dirty);
    int         f;
    logic       wbr, fv, fl, dn, rr;
    logic [3:0] wbi, fi;
    f   = 1 + int'(MEM_LAT) + (dirty ? 16 : 0);
    wbr = dirty && (c >= 1) && (c <= 16);
    wbi = wbr ? 4'(c - 1) : 4'd0;
    fv  = (c >= f) && (c <= f + 15);
    fi  = fv ? 4'(c - f) : 4'd0;
    fl  = fv && (fi == 4'd15);
    dn  = (c == f + 16);
    rr  = (c == f + 17);
    return {wbr, wbi, fv, fi, fl, dn, rr, ~rr};
  endfunction

  task automatic set_exp(input logic [15:0] base, input int n);
    for (int i = 0; i < 16; i++) exp_fill[i] = (i < n) ? base + 16'(i) : 16'd0;
  endtask

  // One transaction; called on a falling edge with req_ready expected high
  task automatic run_txn(input string tag, input logic dirty, input logic [11:0] victim,
                         input logic [11:0] fill, input logic [15:0] base, input logic hold);
    int f;
    f = 1 + int'(MEM_LAT) + (dirty ? 16 : 0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_dirty       = dirty;
    req_victim_line = victim;
    req_fill_line   = fill;
    wb_base         = base;
    @(posedge clk);
    for (int c = 1; c <= f + 17; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Fields must have been latched at accept
        if (!hold) req_valid = 1'b0;
        req_dirty       = ~dirty;
        req_victim_line = ~victim;
        req_fill_line   = ~fill;
      end
      chk($sformatf("%s.ctl@%0d", tag, c), 32'(ctl_now()), 32'(ctl_exp(c, dirty)));
      if (c >= f && c <= f + 15)
        chk($sformatf("%s.data[%0d]", tag, c - f), 32'(fill_data), 32'(exp_fill[c - f]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found;
    n_vec           = 0;
    n_miss          = 0;
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_dirty       = 1'b0;
    req_victim_line = '0;
    req_fill_line   = '0;
    wb_base         = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl", 32'(ctl_now()), 32'd0);
    chk("rst.data", 32'(fill_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel.ctl", 32'(ctl_now()), 32'h2);

    // Clean fill of line 0
    set_exp(16'd0, 0);
    exp_fill[0] = 16'd1500;
    exp_fill[1] = 16'd1020;
    run_txn("clean0", 1'b0, 12'h000, 12'h000, 16'h0, 1'b0);

    // Dirty victim line 1, fill line 8
    set_exp(16'd0, 0);
    exp_fill[0] = 16'd32;
    run_txn("dirty1", 1'b1, 12'h001, 12'h008, 16'h1000, 1'b0);
    set_exp(16'h1000, 16);
    run_txn("rd1", 1'b0, 12'h000, 12'h001, 16'h0, 1'b0);

    // Victim and fill are the same line
    set_exp(16'hA5A0, 16);
    run_txn("same5", 1'b1, 12'h005, 12'h005, 16'hA5A0, 1'b0);

    // req_valid held through the transaction, then back-to-back accept
    set_exp(16'h1000, 16);
    run_txn("hold1", 1'b0, 12'h000, 12'h001, 16'h0, 1'b1);
    set_exp(16'd0, 0);
    exp_fill[0] = 16'd1500;
    exp_fill[1] = 16'd1020;
    run_txn("b2b0", 1'b0, 12'h000, 12'h000, 16'h0, 1'b0);

    // Reset in the middle of a write-back at wb_idx 7
    chk("mid.ready", 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_dirty       = 1'b1;
    req_victim_line = 12'h002;
    req_fill_line   = 12'h003;
    wb_base         = 16'hB000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (wb_ready && wb_idx == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid.reach7", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_ctl", 32'(ctl_now()), 32'd0);
    chk("mid.rst_data", 32'(fill_data), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid.rst_hold", 32'(ctl_now()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid.rel", 32'(ctl_now()), 32'h2);
    set_exp(16'hB000, 7);
    run_txn("rd2", 1'b0, 12'h000, 12'h002, 16'h0, 1'b0);
    set_exp(16'd0, 0);
    exp_fill[0] = 16'd1500;
    exp_fill[1] = 16'd1020;
    run_txn("post0", 1'b0, 12'h000, 12'h000, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
